// File: rtl/data_mem_sized_if.sv
// data_mem_sized_if
//   Load/store bus between the ALU address path, the write-back mux and
//   data_mem_sized.
//   master : drives data_address, write_data, MemRead, MemWrite,
//            access_size, load_unsigned; receives read_data, read_valid,
//            misaligned, out_of_range.
//   slave  : the memory side (data_mem_sized).
`timescale 1ns/1ps
interface data_mem_sized_if;
  logic [31:0] data_address;
  logic [31:0] write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  access_size;
  logic        load_unsigned;
  logic [31:0] read_data;
  logic        read_valid;
  logic        misaligned;
  logic        out_of_range;

  modport master (
    output data_address, write_data, MemRead, MemWrite, access_size, load_unsigned,
    input  read_data, read_valid, misaligned, out_of_range
  );

  modport slave (
    input  data_address, write_data, MemRead, MemWrite, access_size, load_unsigned,
    output read_data, read_valid, misaligned, out_of_range
  );
endinterface

// File: rtl/data_mem_sized.sv
// data_mem_sized
//   Byte-addressed little-endian data memory with byte/half/word loads and
//   stores, signed/unsigned load extension, a registered read path of
//   READ_LATENCY (1 or 2) cycles, and misalignment / out-of-range rejection.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset (outputs and read pipeline only;
//            array contents are kept)
//     bus  - data_mem_sized_if.slave: request inputs (data_address,
//            write_data, MemRead, MemWrite, access_size, load_unsigned) and
//            results (read_data, read_valid, misaligned, out_of_range)
//   Optional: define DM_ERR_STATUS_EN to add
//     err_count - 16-bit saturating count of rejected accesses
//     err_addr  - data_address of the most recent rejected access
`timescale 1ns/1ps
module data_mem_sized #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_sized_if.slave   bus
`ifdef DM_ERR_STATUS_EN
  ,
  output logic [15:0]       err_count,
  output logic [31:0]       err_addr
`endif
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         word_idx;
  logic [1:0]            lane;
  logic                  req;
  logic                  conflict;
  logic                  align_bad;
  logic                  range_bad;
  logic                  is_mis;
  logic                  is_oor;
  logic                  wr_en;
  logic                  rd_en;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [DATA_WIDTH-1:0] rext;
  logic                  mid_valid;
  logic [DATA_WIDTH-1:0] mid_data;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;

  assign word_idx  = bus.data_address[AW+1:2];
  assign lane      = bus.data_address[1:0];
  // Any set bit above the array's byte span means address >= DEPTH*4.
  assign range_bad = |bus.data_address[31:AW+2];

  always_comb begin
    unique case (bus.access_size)
      2'b00:   align_bad = 1'b0;
      2'b01:   align_bad = lane[0];
      2'b10:   align_bad = |lane;
      default: align_bad = 1'b1;
    endcase
  end

  assign req      = bus.MemRead | bus.MemWrite;
  assign conflict = bus.MemRead & bus.MemWrite;
  // Misalignment (including the read/write conflict) masks out_of_range.
  assign is_mis   = req & (align_bad | conflict);
  assign is_oor   = req & ~is_mis & range_bad;
  // A conflicting request still performs its write; only the read is dropped.
  assign wr_en    = bus.MemWrite & ~align_bad & ~range_bad;
  assign rd_en    = bus.MemRead & ~bus.MemWrite & ~align_bad & ~range_bad;

  always_comb begin
    unique case (bus.access_size)
      2'b00:   be = LANES'(1) << lane;
      2'b01:   be = LANES'(3) << lane;
      default: be = '1;
    endcase
  end

  assign wdata_sh = bus.write_data << {lane, 3'b000};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign rword = mem[word_idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = rword[{lane[1], 4'b0000} +: 16];

  always_comb begin
    unique case (bus.access_size)
      2'b00:   rext = bus.load_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   rext = bus.load_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: rext = rword;
    endcase
  end

  // The extended result is captured at the request edge; with latency 2 it
  // passes through one extra register before reaching the output stage.
  assign src_valid = (READ_LATENCY == 2) ? mid_valid : rd_en;
  assign src_data  = (READ_LATENCY == 2) ? mid_data  : rext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mid_valid        <= 1'b0;
      mid_data         <= '0;
      bus.read_valid   <= 1'b0;
      bus.read_data    <= '0;
      bus.misaligned   <= 1'b0;
      bus.out_of_range <= 1'b0;
    end else begin
      mid_valid        <= rd_en;
      if (rd_en) mid_data <= rext;
      bus.read_valid   <= src_valid;
      if (src_valid) bus.read_data <= src_data;
      bus.misaligned   <= is_mis;
      bus.out_of_range <= is_oor;
    end
  end

`ifdef DM_ERR_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      err_addr  <= '0;
    end else if (is_mis | is_oor) begin
      if (err_count != '1) err_count <= err_count + 16'd1;
      err_addr <= bus.data_address;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_sized.sv
`timescale 1ns/1ps
module tb_data_mem_sized;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_sized_if bus1 ();
  data_mem_sized_if bus2 ();

  assign bus2.data_address  = bus1.data_address;
  assign bus2.write_data    = bus1.write_data;
  assign bus2.MemRead       = bus1.MemRead;
  assign bus2.MemWrite      = bus1.MemWrite;
  assign bus2.access_size   = bus1.access_size;
  assign bus2.load_unsigned = bus1.load_unsigned;

`ifdef DM_ERR_STATUS_EN
  logic [15:0] err_count1, err_count2;
  logic [31:0] err_addr1, err_addr2;
  logic [15:0] ecnt;
  logic [31:0] eaddr;
`endif

  data_mem_sized #(.DATA_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef DM_ERR_STATUS_EN
    , .err_count(err_count1), .err_addr(err_addr1)
`endif
  );

  data_mem_sized #(.DATA_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef DM_ERR_STATUS_EN
    , .err_count(err_count2), .err_addr(err_addr2)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference: flat byte array, little-endian.
  byte unsigned mmem [BYTES];
  logic [31:0] hold1, hold2, prev2_d;
  logic        prev2_v;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic        rv;
    logic [31:0] d;
    logic        mis;
    logic        oor;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic uns,
                       output logic mis, output logic oor, output logic rv,
                       output logic [31:0] rdat);
    int unsigned nb;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis  = (rd || wr) && ((rd && wr) || sz == 2'd3 || (a % nb) != 0);
    oor  = (rd || wr) && !mis && (a >= BYTES);
    rv   = rd && !mis && !oor;
    rdat = '0;
    if (rv) begin
      for (int k = 0; k < int'(nb); k++) rdat |= 32'(mmem[a + 32'(k)]) << (8 * k);
      if (!uns && nb < 4 && rdat[8*nb-1]) rdat |= 32'hFFFF_FFFF << (8 * nb);
    end
    if (wr && sz != 2'd3 && (a % nb) == 0 && a < BYTES)
      for (int k = 0; k < int'(nb); k++) mmem[a + 32'(k)] = 8'(wd >> (8 * k));
  endtask

  // Apply one request, let one clock edge pass, then compare both instances.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                      input logic wr, input logic [1:0] sz, input logic uns);
    logic mis, oor, rv;
    logic [31:0] rdat;
    bus1.data_address  = a;
    bus1.write_data    = wd;
    bus1.MemRead       = rd;
    bus1.MemWrite      = wr;
    bus1.access_size   = sz;
    bus1.load_unsigned = uns;
    model(a, wd, rd, wr, sz, uns, mis, oor, rv, rdat);
    @(posedge clk);
    #1;
    if (rv) hold1 = rdat;
    chk1("rv_lat1", bus1.read_valid, rv);
    chk("rdata_lat1", bus1.read_data, hold1);
    if (prev2_v) hold2 = prev2_d;
    chk1("rv_lat2", bus2.read_valid, prev2_v);
    chk("rdata_lat2", bus2.read_data, hold2);
    prev2_v = rv;
    prev2_d = rdat;
    chk1("mis_lat1", bus1.misaligned, mis);
    chk1("oor_lat1", bus1.out_of_range, oor);
    chk1("mis_lat2", bus2.misaligned, mis);
    chk1("oor_lat2", bus2.out_of_range, oor);
`ifdef DM_ERR_STATUS_EN
    if (mis || oor) begin
      if (ecnt != 16'hFFFF) ecnt++;
      eaddr = a;
    end
    chk("err_count1", 32'(err_count1), 32'(ecnt));
    chk("err_addr1", err_addr1, eaddr);
    chk("err_count2", 32'(err_count2), 32'(ecnt));
    chk("err_addr2", err_addr2, eaddr);
`endif
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
  endtask

  // Asserts rst #1 after an edge, checks the asynchronous clear, releases it.
  task automatic do_reset();
    bus1.MemRead  = 1'b0;
    bus1.MemWrite = 1'b0;
    rst = 1'b1;
    #1;
    chk1("rst_rv1", bus1.read_valid, 1'b0);
    chk("rst_rdata1", bus1.read_data, 32'h0);
    chk1("rst_mis1", bus1.misaligned, 1'b0);
    chk1("rst_oor1", bus1.out_of_range, 1'b0);
    chk1("rst_rv2", bus2.read_valid, 1'b0);
    chk("rst_rdata2", bus2.read_data, 32'h0);
    chk1("rst_mis2", bus2.misaligned, 1'b0);
    chk1("rst_oor2", bus2.out_of_range, 1'b0);
`ifdef DM_ERR_STATUS_EN
    chk("rst_errcnt", 32'(err_count1), 32'h0);
    chk("rst_erraddr", err_addr1, 32'h0);
    ecnt  = '0;
    eaddr = '0;
`endif
    hold1   = '0;
    hold2   = '0;
    prev2_v = 1'b0;
    prev2_d = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b1;
    bus1.data_address  = '0;
    bus1.write_data    = '0;
    bus1.MemRead       = 1'b0;
    bus1.MemWrite      = 1'b0;
    bus1.access_size   = 2'b10;
    bus1.load_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Known contents everywhere so random loads are fully predictable.
    for (int i = 0; i < int'(DEPTH); i++) step(32'(i * 4), $urandom, 1'b0, 1'b1, 2'b10, 1'b0);

    //                 a             wd            rd   wr   sz     uns  rv   d             mis  oor
    tbl.push_back(vec_t'{32'h000, 32'h00000000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h002, 32'h12345680, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h002, 32'h00000000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h002, 32'h00000000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h00000080, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h000, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h00800000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h000, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h000, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h004, 32'h00000000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h006, 32'hABCD8001, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h006, 32'h00000000, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'hFFFF8001, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h006, 32'h00000000, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h00008001, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h005, 32'h00000000, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0});
    tbl.push_back(vec_t'{32'h004, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h80010000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h400, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1});
    tbl.push_back(vec_t'{32'h400, 32'h11111111, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1});
    tbl.push_back(vec_t'{32'h000, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h402, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0});
    tbl.push_back(vec_t'{32'h008, 32'h00000000, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0});
    tbl.push_back(vec_t'{32'h008, 32'h55AA33CC, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h00C, 32'h12345678, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0});
    tbl.push_back(vec_t'{32'h00C, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h3FC, 32'hCAFEF00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h3FC, 32'h00000000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h3FD, 32'h00000000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h000000F0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{32'h3FE, 32'h00000000, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'hFFFFCAFE, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns);
      chk1("tbl_rv", bus1.read_valid, tbl[i].rv);
      if (tbl[i].rv) chk("tbl_data", bus1.read_data, tbl[i].d);
      chk1("tbl_mis", bus1.misaligned, tbl[i].mis);
      chk1("tbl_oor", bus1.out_of_range, tbl[i].oor);
`ifdef DM_ERR_STATUS_EN
      if (tbl[i].a == 32'h00C && tbl[i].rd && tbl[i].wr) chk("tbl_err_addr", err_addr1, 32'h0000000C);
`endif
    end
    idle();

    // Back-to-back word loads through the two-cycle instance.
    step(32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    chk1("b2b_rv_a", bus2.read_valid, 1'b0);
    step(32'h4, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    chk1("b2b_rv_b", bus2.read_valid, 1'b1);
    chk("b2b_d0", bus2.read_data, 32'hDEADBEEF);
    step(32'h8, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    chk1("b2b_rv_c", bus2.read_valid, 1'b1);
    chk("b2b_d1", bus2.read_data, 32'h80010000);
    idle();
    chk1("b2b_rv_d", bus2.read_valid, 1'b1);
    chk("b2b_d2", bus2.read_data, 32'h55AA33CC);
    idle();
    chk1("b2b_rv_e", bus2.read_valid, 1'b0);

    // Reset while the second of three loads is still in the pipeline.
    step(32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    step(32'h4, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk1("rst_drop_rv2", bus2.read_valid, 1'b0);
      chk1("rst_drop_rv1", bus1.read_valid, 1'b0);
    end
    step(32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    chk("post_rst_mem", bus1.read_data, 32'hDEADBEEF);

    // Randomized traffic against the byte-array reference.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int unsigned op;
      logic        rd, wr;
      op = $urandom_range(0, 10);
      rd = (op >= 1 && op <= 5) || op == 10;
      wr = (op >= 6 && op <= 9) || op == 10;
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
      a = 32'($urandom_range(0, BYTES - 1));
      case ($urandom_range(0, 9))
        0:       a = BYTES + 32'($urandom_range(0, 255));
        1:       a = $urandom;
        default: ;
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a[1:0] = 2'b00;
        else if (sz == 2'd1) a[0] = 1'b0;
      end
      step(a, $urandom, rd, wr, sz, 1'($urandom_range(0, 1)));
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
- Parametrised successor to the single-cycle data memory: byte-addressed, little-endian word array with byte, halfword and word loads/stores.
- Signed and unsigned loads; configurable registered read latency.
- Misalignment and out-of-range detection.
- Sits between the ALU address output and the write-back mux; the load unit consumes read_data only while read_valid is high.

Parameters:
- DATA_WIDTH, 32, word width in bits; fixed at 32 for this generation, byte lanes = DATA_WIDTH/8.
- DEPTH, 256, number of words; power of two, 4..65536.
- READ_LATENCY, 1, cycles from read request to read_valid; legal values 1 or 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- data_address  input  32  byte address.
- write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- MemRead  input  1  load request, sampled at rising edge.
- MemWrite  input  1  store request, sampled at rising edge.
- access_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (flags misaligned).
- load_unsigned  input  1  1 zero-extends, 0 sign-extends byte/half loads.
- read_data  output  32  extended load result.
- read_valid  output  1  one-cycle pulse, read_data valid.
- misaligned  output  1  one-cycle pulse, rejected access due to alignment/reserved size.
- out_of_range  output  1  one-cycle pulse, rejected access with address >= DEPTH*4.

Behaviour:
- Reset (async, rst=1): read_data=0, read_valid=0, misaligned=0, out_of_range=0; read pipeline flushed. Array contents are not reset.
- Reset mid-read: the pending read is discarded; no read_valid after rst deasserts.
- Word index = data_address[log2(DEPTH)+1:2]; byte lane = data_address[1:0].
- Alignment: half requires address[0]=0; word requires address[1:0]=00; access_size=11 is always misaligned.
- Range: any data_address >= DEPTH*4 is out of range. If both conditions hold, only misaligned pulses.
- Rejected access: no array change, no read_valid. The flag pulses the cycle after the request edge, for reads and writes alike.
- Store: at the rising edge with MemWrite=1 and the access legal, only the addressed lanes update. Byte writes lane addr[1:0] with write_data[7:0]. Half writes lanes {addr[1],0}+1..+0 with write_data[15:0]. Word writes all four lanes.
- Load: the word is read at the request edge.
  - READ_LATENCY=1: read_data/read_valid are registered and valid in the cycle after the request edge.
  - READ_LATENCY=2: one extra pipeline stage.
  - Back-to-back reads are accepted every cycle, with results in order.
- Extension: the selected byte/half is shifted to bit 0 and extended per the load_unsigned value captured with the request.
- MemRead and MemWrite both high: the write executes and the read is dropped (no read_valid). misaligned pulses to signal a protocol conflict.
- Read-after-write: a read issued the cycle after a write to the same word returns the new data. No same-edge forwarding is needed, since simultaneous requests are rejected.
- read_data holds its last valid value when read_valid=0.

Optional Feature:
- Macro DM_ERR_STATUS_EN.
- When defined, adds two outputs:
  - err_count (16 bits): saturating count of misaligned plus out_of_range pulses.
  - err_addr (32 bits): data_address of the most recent rejected access.
  - Both are cleared by rst only.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Word store addr 0x0 data 0xDEADBEEF, then word load addr 0x0 -> read_valid after READ_LATENCY cycles, read_data=0xDEADBEEF.
- Byte store 0x80 to addr 0x2 over 0x00000000, then lb addr 0x2 -> 0xFFFFFF80; lbu -> 0x00000080; lw -> 0x00800000.
- Half store 0x8001 to addr 0x6, then lh -> 0xFFFF8001, lhu -> 0x00008001. lh addr 0x5 -> misaligned pulse, no read_valid, memory unchanged.
- Word load addr DEPTH*4 (0x400 for default) -> out_of_range pulse, no read_valid. Word store there -> out_of_range pulse, array unchanged (verify addr 0x0 still 0xDEADBEEF).
- Back-to-back lw of addr 0x0,0x4,0x8 on consecutive cycles, READ_LATENCY=2 -> three consecutive read_valid pulses with data in order. Assert rst during the second -> all outputs 0 immediately, no further read_valid.
- MemRead=MemWrite=1 at addr 0xC with data 0x12345678 -> misaligned pulse, no read_valid, subsequent lw 0xC=0x12345678. With DM_ERR_STATUS_EN: err_count increments, err_addr=0x0000000C.
